rom_arbiter: RTL and testbench

Shares one single-port ROM (Altera ROM IP, registered address and output) between two independent read requesters, e.g. the key-driven address sequencer and a display/UART reader. Requests are arbitrated round-robin, one ROM access per cycle, and each read returns data tagged back to the requester that issued it. The block sits between the requesters and the ROM instance; it owns the ROM address bus exclusively.

---
 rtl/rom_arbiter_if.sv | 32 +++
 rtl/rom_arbiter.sv | 76 +++++++
 tb/tb_rom_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_if.sv
// Requester-side and ROM-side signals of rom_arbiter, bundled with
// modports for the arbiter (slave) and its environment (master).
interface rom_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic              rom_rden;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;

  modport master (
    output req0, addr0, req1, addr1, rom_q,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_rden, rom_addr
  );

  modport slave (
    input  req0, addr0, req1, addr1, rom_q,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_rden, rom_addr
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one registered single-port ROM between two
// read requesters; each read's data is routed back by a tag pipeline.
module rom_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 2
) (
  input logic          i_sys_clk,
  input logic          i_sys_rst,
  rom_arbiter_if.slave bus
);

  logic w_elig0, w_elig1;
  logic w_win0, w_win1;
  logic w_resp0, w_resp1;

  logic              r_gnt0, r_gnt1;
  logic              r_rden;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [RD_LAT:0]   r_tag_v;
  logic [RD_LAT:0]   r_tag_id;
  logic              r_rvalid0, r_rvalid1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;

  always_comb begin
    // A request still high during its own grant cycle is the old one.
    w_elig0 = bus.req0 & ~r_gnt0;
    w_elig1 = bus.req1 & ~r_gnt1;
    w_win0  = w_elig0 & (~w_elig1 | r_last);
    w_win1  = w_elig1 & (~w_elig0 | ~r_last);
    // The last tag stage lines up with the cycle rom_q is valid.
    w_resp0 = r_tag_v[RD_LAT] & ~r_tag_id[RD_LAT];
    w_resp1 = r_tag_v[RD_LAT] & r_tag_id[RD_LAT];
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rden    <= 1'b0;
      r_last    <= 1'b1;
      r_addr    <= '0;
      r_tag_v   <= '0;
      r_tag_id  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_gnt0   <= w_win0;
      r_gnt1   <= w_win1;
      r_rden   <= w_win0 | w_win1;
      if (w_win0 | w_win1) begin
        r_addr <= w_win0 ? bus.addr0 : bus.addr1;
        r_last <= w_win1;
      end
      r_tag_v   <= {r_tag_v[RD_LAT-1:0], w_win0 | w_win1};
      r_tag_id  <= {r_tag_id[RD_LAT-1:0], w_win1};
      r_rvalid0 <= w_resp0;
      r_rvalid1 <= w_resp1;
      if (w_resp0) r_rdata0 <= bus.rom_q;
      if (w_resp1) r_rdata1 <= bus.rom_q;
    end
  end

  assign bus.gnt0     = r_gnt0;
  assign bus.gnt1     = r_gnt1;
  assign bus.rom_rden = r_rden;
  assign bus.rom_addr = r_addr;
  assign bus.rvalid0  = r_rvalid0;
  assign bus.rvalid1  = r_rvalid1;
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: cycle table of grants plus a response scoreboard,
// with a ROM model returning ~addr after two registered stages.
module tb_rom_arbiter;

  typedef struct {
    bit         r0;
    logic [7:0] a0;
    bit         r1;
    logic [7:0] a1;
    bit         eg0;
    bit         eg1;
    logic [7:0] eaddr;
  } vec_t;

  typedef struct {
    bit         id;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rom_a;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  vec_t vecs[$];
  exp_t sb_q[$];

  rom_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  rom_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // ROM model: registered address, registered output.
  always @(posedge clk) begin
    rom_a     <= bus.rom_addr;
    bus.rom_q <= ~rom_a;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(bit r0, logic [7:0] a0, bit r1, logic [7:0] a1);
    #1;
    bus.req0  = r0;
    bus.addr0 = a0;
    bus.req1  = r1;
    bus.addr1 = a1;
  endtask

  task automatic add(bit r0, logic [7:0] a0, bit r1, logic [7:0] a1,
                     bit g0, bit g1, logic [7:0] ea);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
    v.eg0 = g0; v.eg1 = g1; v.eaddr = ea;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.addr0 = '0; bus.req1 = 1'b0; bus.addr1 = '0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_gnt0"}, 32'(bus.gnt0), 0);
    chk({tag, "_gnt1"}, 32'(bus.gnt1), 0);
    chk({tag, "_rvalid0"}, 32'(bus.rvalid0), 0);
    chk({tag, "_rvalid1"}, 32'(bus.rvalid1), 0);
    chk({tag, "_rden"}, 32'(bus.rom_rden), 0);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
    chk({tag, "_rdata0"}, 32'(bus.rdata0), 0);
    chk({tag, "_rdata1"}, 32'(bus.rdata1), 0);
  endtask

  task automatic single_read(bit id, logic [7:0] a, logic [7:0] exp_d);
    int n;
    logic rv;
    set_in(!id, a, id, a);
    @(negedge clk);
    chk("single_gnt", 32'(id ? bus.gnt1 : bus.gnt0), 1);
    chk("single_rom_addr", 32'(bus.rom_addr), 32'(a));
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    n = 1;
    rv = 1'b0;
    while (!rv && n < 12) begin
      @(negedge clk);
      n++;
      rv = id ? bus.rvalid1 : bus.rvalid0;
    end
    chk("single_latency", 32'(n), 4);
    chk("single_rdata", 32'(id ? bus.rdata1 : bus.rdata0), 32'(exp_d));
  endtask

  // Scoreboard: grants push the expected response, rvalid pulses pop it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sb_q.delete();
      end else begin
        chk("rvalid_excl", 32'(bus.rvalid0 & bus.rvalid1), 0);
        chk("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 0);
        if (bus.rvalid0 || bus.rvalid1) begin
          chk("rvalid_expected", 32'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("resp_id", 32'(bus.rvalid1), 32'(e.id));
            chk("resp_data", 32'(bus.rvalid1 ? bus.rdata1 : bus.rdata0), 32'(e.data));
            chk("resp_cycle", 32'(cyc), 32'(e.due));
          end
        end
        while (sb_q.size() != 0 && sb_q[0].due < cyc) begin
          chk("resp_timely", 32'(sb_q[0].due), 32'(cyc));
          void'(sb_q.pop_front());
        end
        if (bus.gnt0) begin
          e.id = 1'b0; e.data = ~bus.addr0; e.due = cyc + 3;
          sb_q.push_back(e);
        end
        if (bus.gnt1) begin
          e.id = 1'b1; e.data = ~bus.addr1; e.due = cyc + 3;
          sb_q.push_back(e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Sustained contention: both held, each advances its address per grant.
    for (int k = 0; k < 20; k++) begin
      add(1'b1, 8'((k + 1) / 2), 1'b1, 8'(8'h80 + k / 2), (k % 2) == 0, (k % 2) == 1,
          ((k % 2) == 0) ? 8'((k + 1) / 2) : 8'(8'h80 + k / 2));
    end
    for (int k = 0; k < 5; k++) add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h89);
    // Single requester streaming: grant only every other cycle.
    for (int k = 0; k < 10; k++) add(1'b1, 8'h55, 1'b0, 8'h00, (k % 2) == 0, 1'b0, 8'h55);
    for (int k = 0; k < 4; k++) add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h55);
    // Address extremes.
    add(1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF);
    add(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF);
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 6; k++) add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    bus.req0 = 1'b0; bus.addr0 = '0; bus.req1 = 1'b0; bus.addr1 = '0;
    @(negedge clk);
    do_reset();
    chk_all_zero("reset");

    single_read(1'b1, 8'hC7, 8'h38);
    single_read(1'b0, 8'h63, 8'h9C);
    repeat (2) @(negedge clk);

    // Tie after reset must go to requester 0 even though 0 won last.
    do_reset();
    set_in(1'b1, 8'h10, 1'b1, 8'h20);
    @(negedge clk);
    chk("tie_gnt0", 32'(bus.gnt0), 1);
    chk("tie_gnt1_idle", 32'(bus.gnt1), 0);
    set_in(1'b0, 8'h00, 1'b1, 8'h20);
    @(negedge clk);
    chk("tie_gnt1", 32'(bus.gnt1), 1);
    chk("tie_rom_addr", 32'(bus.rom_addr), 32'h20);
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    chk("tie_rvalid0", 32'(bus.rvalid0), 1);
    chk("tie_rdata0", 32'(bus.rdata0), 32'hEF);
    @(negedge clk);
    chk("tie_rvalid1", 32'(bus.rvalid1), 1);
    chk("tie_rdata1", 32'(bus.rdata1), 32'hDF);
    repeat (2) @(negedge clk);

    foreach (vecs[k]) begin
      set_in(vecs[k].r0, vecs[k].a0, vecs[k].r1, vecs[k].a1);
      @(negedge clk);
      chk($sformatf("row%0d_gnt0", k), 32'(bus.gnt0), 32'(vecs[k].eg0));
      chk($sformatf("row%0d_gnt1", k), 32'(bus.gnt1), 32'(vecs[k].eg1));
      chk($sformatf("row%0d_rden", k), 32'(bus.rom_rden), 32'(vecs[k].eg0 | vecs[k].eg1));
      chk($sformatf("row%0d_rom_addr", k), 32'(bus.rom_addr), 32'(vecs[k].eaddr));
    end
    chk("table_drained", 32'(sb_q.size()), 0);

    // Reset one cycle after gnt1: that read must never return.
    set_in(1'b0, 8'h00, 1'b1, 8'h3C);
    @(negedge clk);
    chk("mid_gnt1", 32'(bus.gnt1), 1);
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    #1;
    rst = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 8'h44; bus.req1 = 1'b1; bus.addr1 = 8'h45;
    @(negedge clk);
    chk("mid_tie_gnt0", 32'(bus.gnt0), 1);
    chk("mid_tie_gnt1", 32'(bus.gnt1), 0);
    chk("mid_no_rvalid1", 32'(bus.rvalid1), 0);
    set_in(1'b0, 8'h00, 1'b1, 8'h45);
    @(negedge clk);
    chk("mid_next_gnt1", 32'(bus.gnt1), 1);
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    repeat (8) @(negedge clk);
    chk("final_drained", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
